// File: rtl/s_wallace_dot_acc.sv
// Streaming dot-product accumulator: sums DOT_LEN signed products into a
// saturating (or wrapping) accumulator and hands the result off over valid/ready.
module s_wallace_dot_acc #(
  parameter int unsigned PROD_W   = 8,
  parameter int unsigned ACC_W    = 8,
  parameter int unsigned DOT_LEN  = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf
);

  localparam int unsigned CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_res;
  logic               r_res_valid;
  logic               r_ovf;

  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf_now;
  logic [ACC_W-1:0]   w_next_acc;
  logic               w_accept;
  logic               w_last;

  // One guard bit above the accumulator exposes signed overflow.
  assign w_sum     = SUM_W'($signed(r_acc)) + SUM_W'($signed(prod));
  assign w_ovf_now = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_next_acc = w_sum[ACC_W-1:0];
    if (SATURATE && w_ovf_now) begin
      // Guard bit carries the true sign of the unbounded sum.
      if (w_sum[ACC_W]) w_next_acc = {1'b1, {(ACC_W-1){1'b0}}};
      else              w_next_acc = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign in_ready = (r_state == ST_ACC);
  assign w_accept = in_valid && in_ready && !clr;
  assign w_last   = (r_cnt == CNT_W'(DOT_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end else if (w_accept) begin
            r_ovf <= r_ovf | w_ovf_now;
            if (w_last) begin
              r_res       <= w_next_acc;
              r_res_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_DONE;
            end else begin
              r_acc <= w_next_acc;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Pending result survives clr; only the consumer releases it.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_state     <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign ovf       = r_ovf;

endmodule
